// File: rtl/i2c_eeprom_target.sv
// I2C target emulating a 24C02-style 256x8 EEPROM; SCL/SDA are oversampled by clk.
// Open-drain SDA: sda_oe=1 pulls the line low, the block never drives it high.
`timescale 1ns/1ps
module i2c_eeprom_target #(
   parameter logic [6:0] DEV_ADDR = 7'h50
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       scl_in,
   input  logic       sda_in,
   output logic       sda_oe,
   output logic [7:0] mem_addr,
   output logic [7:0] mem_wdata,
   output logic       mem_we,
   output logic       mem_re,
   input  logic [7:0] mem_rdata,
   output logic       busy,
   output logic       stop_det
);

   typedef enum logic [2:0] {IDLE, ADDR, ACK_W, RX, ACK_R, TX, MACK} state_t;

   state_t     state, state_n;
   logic       scl_p0, scl_p1, scl_p2;
   logic       sda_p0, sda_p1, sda_p2;
   logic       scl_rise, scl_fall, start_cond, stop_cond;
   logic [3:0] cnt, cnt_n;
   logic [7:0] shreg, shreg_n;
   logic [7:0] ptr, ptr_n;
   logic [7:0] rx_byte;
   logic       ack_ph, ack_ph_n;
   logic       first_byte, first_n;
   logic       re_d;
   logic       oe_n, we_n, re_n, busy_n, stop_n;
   logic [7:0] wdata_n;

   // stage p0/p1: synchronisers, p2: previous sample for edge detection
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         scl_p0 <= 1'b1;
         scl_p1 <= 1'b1;
         scl_p2 <= 1'b1;
         sda_p0 <= 1'b1;
         sda_p1 <= 1'b1;
         sda_p2 <= 1'b1;
      end else begin
         scl_p0 <= scl_in;
         scl_p1 <= scl_p0;
         scl_p2 <= scl_p1;
         sda_p0 <= sda_in;
         sda_p1 <= sda_p0;
         sda_p2 <= sda_p1;
      end
   end

   assign scl_rise   = scl_p1 & ~scl_p2;
   assign scl_fall   = ~scl_p1 & scl_p2;
   assign start_cond = scl_p1 & scl_p2 & sda_p2 & ~sda_p1;
   assign stop_cond  = scl_p1 & scl_p2 & ~sda_p2 & sda_p1;
   assign rx_byte    = {shreg[6:0], sda_p1};
   assign mem_addr   = ptr;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= 4'd0;
         shreg      <= 8'd0;
         ptr        <= 8'd0;
         ack_ph     <= 1'b0;
         first_byte <= 1'b0;
         re_d       <= 1'b0;
         sda_oe     <= 1'b0;
         mem_wdata  <= 8'd0;
         mem_we     <= 1'b0;
         mem_re     <= 1'b0;
         busy       <= 1'b0;
         stop_det   <= 1'b0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         shreg      <= shreg_n;
         ptr        <= ptr_n;
         ack_ph     <= ack_ph_n;
         first_byte <= first_n;
         re_d       <= mem_re;
         sda_oe     <= oe_n;
         mem_wdata  <= wdata_n;
         mem_we     <= we_n;
         mem_re     <= re_n;
         busy       <= busy_n;
         stop_det   <= stop_n;
      end
   end

   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      shreg_n  = shreg;
      ptr_n    = ptr;
      ack_ph_n = ack_ph;
      first_n  = first_byte;
      oe_n     = sda_oe;
      wdata_n  = mem_wdata;
      we_n     = 1'b0;
      re_n     = 1'b0;
      busy_n   = busy;
      stop_n   = 1'b0;

      // pointer advances on the cycle after a write strobe; read data lands one cycle after mem_re
      if (mem_we) ptr_n = ptr + 8'd1;
      if (re_d) shreg_n = mem_rdata;

      if (stop_cond) begin
         state_n  = IDLE;
         oe_n     = 1'b0;
         busy_n   = 1'b0;
         stop_n   = 1'b1;
         ack_ph_n = 1'b0;
      end else if (start_cond) begin
         state_n  = ADDR;
         cnt_n    = 4'd0;
         oe_n     = 1'b0;
         ack_ph_n = 1'b0;
      end else begin
         case (state)
            ADDR: if (scl_rise) begin
               shreg_n = rx_byte;
               cnt_n   = cnt + 4'd1;
               if (cnt == 4'd7) begin
                  cnt_n = 4'd0;
                  if (rx_byte[7:1] != DEV_ADDR) begin
                     state_n = IDLE;
                     busy_n  = 1'b0;
                  end else if (rx_byte[0]) begin
                     state_n = ACK_R;
                     busy_n  = 1'b1;
                     re_n    = 1'b1;
                  end else begin
                     state_n = ACK_W;
                     busy_n  = 1'b1;
                     first_n = 1'b1;
                  end
               end
            end
            ACK_W: if (scl_fall) begin
               if (!ack_ph) begin
                  oe_n     = 1'b1;
                  ack_ph_n = 1'b1;
               end else begin
                  oe_n     = 1'b0;
                  ack_ph_n = 1'b0;
                  cnt_n    = 4'd0;
                  state_n  = RX;
               end
            end
            RX: if (scl_rise) begin
               shreg_n = rx_byte;
               cnt_n   = cnt + 4'd1;
               if (cnt == 4'd7) begin
                  cnt_n   = 4'd0;
                  state_n = ACK_W;
                  if (first_byte) begin
                     ptr_n   = rx_byte;
                     first_n = 1'b0;
                  end else begin
                     we_n    = 1'b1;
                     wdata_n = rx_byte;
                  end
               end
            end
            ACK_R: if (scl_fall) begin
               if (!ack_ph) begin
                  oe_n     = 1'b1;
                  ack_ph_n = 1'b1;
               end else begin
                  oe_n     = ~shreg[7];
                  shreg_n  = {shreg[6:0], 1'b0};
                  cnt_n    = 4'd1;
                  ack_ph_n = 1'b0;
                  state_n  = TX;
               end
            end
            TX: if (scl_fall) begin
               if (cnt == 4'd8) begin
                  // pointer moves past the byte just sent, whether the master ACKs or not
                  oe_n    = 1'b0;
                  cnt_n   = 4'd0;
                  ptr_n   = ptr + 8'd1;
                  state_n = MACK;
               end else begin
                  oe_n    = ~shreg[7];
                  shreg_n = {shreg[6:0], 1'b0};
                  cnt_n   = cnt + 4'd1;
               end
            end
            MACK: begin
               if (!ack_ph) begin
                  if (scl_rise) begin
                     if (sda_p1) begin
                        state_n = IDLE;
                        busy_n  = 1'b0;
                     end else begin
                        re_n     = 1'b1;
                        ack_ph_n = 1'b1;
                     end
                  end
               end else if (scl_fall) begin
                  oe_n     = ~shreg[7];
                  shreg_n  = {shreg[6:0], 1'b0};
                  cnt_n    = 4'd1;
                  ack_ph_n = 1'b0;
                  state_n  = TX;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_eeprom_target.sv
// Directed bench for i2c_eeprom_target: bit-banged I2C master plus a 256x8 memory model.
`timescale 1ns/1ps
module tb_i2c_eeprom_target;

   localparam int Q = 8;
   localparam int H = 2;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       scl = 1'b1;
   logic       sda_m = 1'b1;
   wire        sda_bus = sda_m & ~sda_oe;
   logic       sda_oe;
   logic [7:0] mem_addr, mem_wdata, mem_rdata;
   logic       mem_we, mem_re, busy, stop_det;

   int n_chk = 0;
   int n_bad = 0;

   logic [7:0] mem [256];
   logic [7:0] we_a [16];
   logic [7:0] we_d [16];
   logic [7:0] re_a [16];
   int we_cnt = 0, re_cnt = 0, stops = 0, oe_cnt = 0, busy_cnt = 0;

   always #5 clk = ~clk;

   i2c_eeprom_target #(.DEV_ADDR(7'h50)) dut (
      .clk(clk), .reset(reset), .scl_in(scl), .sda_in(sda_bus), .sda_oe(sda_oe),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
      .mem_rdata(mem_rdata), .busy(busy), .stop_det(stop_det)
   );

   // memory contents while untouched: addr ^ 0xA5
   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'hA5;
         mem_rdata <= 8'd0;
      end else begin
         if (mem_we) mem[mem_addr] <= mem_wdata;
         if (mem_re) mem_rdata <= mem[mem_addr];
      end
   end

   always @(negedge clk) begin
      if (mem_we) begin
         if (we_cnt < 16) begin
            we_a[we_cnt] = mem_addr;
            we_d[we_cnt] = mem_wdata;
         end
         we_cnt++;
      end
      if (mem_re) begin
         if (re_cnt < 16) re_a[re_cnt] = mem_addr;
         re_cnt++;
      end
      if (stop_det) stops++;
      if (sda_oe) oe_cnt++;
      if (busy) busy_cnt++;
   end

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic wt(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic i2c_start();
      wt(H); sda_m = 1'b1; wt(Q); scl = 1'b1; wt(Q); sda_m = 1'b0; wt(Q); scl = 1'b0;
   endtask

   task automatic i2c_stop();
      wt(H); sda_m = 1'b0; wt(Q); scl = 1'b1; wt(Q); sda_m = 1'b1; wt(Q);
   endtask

   task automatic write_byte(input logic [7:0] b, output logic ack);
      for (int i = 7; i >= 0; i--) begin
         wt(H); sda_m = b[i]; wt(Q); scl = 1'b1; wt(Q); scl = 1'b0;
      end
      wt(H); sda_m = 1'b1; wt(Q); scl = 1'b1; wt(Q / 2); ack = sda_bus; wt(Q / 2); scl = 1'b0;
   endtask

   task automatic read_byte(input logic nack, output logic [7:0] d);
      for (int i = 7; i >= 0; i--) begin
         wt(H); sda_m = 1'b1; wt(Q); scl = 1'b1; wt(Q / 2); d[i] = sda_bus; wt(Q / 2); scl = 1'b0;
      end
      wt(H); sda_m = nack; wt(Q); scl = 1'b1; wt(Q); scl = 1'b0;
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_oe"}, 8'(sda_oe), 8'd0);
      check({tag, "_addr"}, mem_addr, 8'd0);
      check({tag, "_wdata"}, mem_wdata, 8'd0);
      check({tag, "_we_re"}, {6'd0, mem_we, mem_re}, 8'd0);
      check({tag, "_busy"}, 8'(busy), 8'd0);
      check({tag, "_stopdet"}, 8'(stop_det), 8'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic       ack;
      logic [7:0] d;
      int         base_we, base_re, base_oe, base_busy, waited;

      wt(5);
      check_idle_outputs("reset");
      reset = 1'b0;
      wt(10);

      // sequential write: 0x5A @0x10, 0xC3 @0x11
      base_we = we_cnt;
      i2c_start();
      write_byte(8'hA0, ack); check("wr_ack_dev", 8'(ack), 8'd0);
      check("wr_busy", 8'(busy), 8'd1);
      write_byte(8'h10, ack); check("wr_ack_wa", 8'(ack), 8'd0);
      write_byte(8'h5A, ack); check("wr_ack_d0", 8'(ack), 8'd0);
      write_byte(8'hC3, ack); check("wr_ack_d1", 8'(ack), 8'd0);
      i2c_stop();
      check("wr_we_count", 8'(we_cnt - base_we), 8'd2);
      check("wr_we0_addr", we_a[base_we], 8'h10);
      check("wr_we0_data", we_d[base_we], 8'h5A);
      check("wr_we1_addr", we_a[base_we + 1], 8'h11);
      check("wr_we1_data", we_d[base_we + 1], 8'hC3);
      check("wr_ptr_end", mem_addr, 8'h12);
      check("wr_stops", 8'(stops), 8'd1);
      check("wr_busy_end", 8'(busy), 8'd0);

      // random read from 0x10, two bytes
      base_re = re_cnt;
      i2c_start();
      write_byte(8'hA0, ack); check("rr_ack_dev", 8'(ack), 8'd0);
      write_byte(8'h10, ack); check("rr_ack_wa", 8'(ack), 8'd0);
      i2c_start();
      write_byte(8'hA1, ack); check("rr_ack_rd", 8'(ack), 8'd0);
      read_byte(1'b0, d); check("rr_data0", d, 8'h5A);
      read_byte(1'b1, d); check("rr_data1", d, 8'hC3);
      i2c_stop();
      check("rr_re_count", 8'(re_cnt - base_re), 8'd2);
      check("rr_re0_addr", re_a[base_re], 8'h10);
      check("rr_re1_addr", re_a[base_re + 1], 8'h11);
      check("rr_ptr_end", mem_addr, 8'h12);
      check("rr_stops", 8'(stops), 8'd2);

      // address mismatch
      base_we = we_cnt; base_re = re_cnt; base_oe = oe_cnt; base_busy = busy_cnt;
      i2c_start();
      write_byte(8'hA2, ack); check("mm_no_ack", 8'(ack), 8'd1);
      write_byte(8'h55, ack); check("mm_no_ack2", 8'(ack), 8'd1);
      i2c_stop();
      check("mm_oe_never", 8'(oe_cnt - base_oe), 8'd0);
      check("mm_busy_never", 8'(busy_cnt - base_busy), 8'd0);
      check("mm_no_mem", 8'((we_cnt - base_we) + (re_cnt - base_re)), 8'd0);
      check("mm_stops", 8'(stops), 8'd3);

      // pointer wrap: 0x11 @0xFF, 0x22 @0x00
      base_we = we_cnt;
      i2c_start();
      write_byte(8'hA0, ack); check("wp_ack_dev", 8'(ack), 8'd0);
      write_byte(8'hFF, ack); check("wp_ack_wa", 8'(ack), 8'd0);
      write_byte(8'h11, ack); check("wp_ack_d0", 8'(ack), 8'd0);
      write_byte(8'h22, ack); check("wp_ack_d1", 8'(ack), 8'd0);
      i2c_stop();
      check("wp_we0_addr", we_a[base_we], 8'hFF);
      check("wp_we0_data", we_d[base_we], 8'h11);
      check("wp_we1_addr", we_a[base_we + 1], 8'h00);
      check("wp_we1_data", we_d[base_we + 1], 8'h22);
      check("wp_ptr_end", mem_addr, 8'h01);

      // current-address read at 0x01 (untouched: 0x01^0xA5 = 0xA4), master NACKs
      base_re = re_cnt;
      i2c_start();
      write_byte(8'hA1, ack); check("nk_ack_dev", 8'(ack), 8'd0);
      read_byte(1'b1, d); check("nk_data", d, 8'hA4);
      wt(4);
      check("nk_busy", 8'(busy), 8'd0);
      check("nk_ptr", mem_addr, 8'h02);
      wt(40);
      check("nk_re_count", 8'(re_cnt - base_re), 8'd1);
      check("nk_re_addr", re_a[base_re], 8'h01);
      check("nk_stops_pre", 8'(stops), 8'd4);
      i2c_stop();
      check("nk_stops", 8'(stops), 8'd5);

      // reset while transmitting 0xA7 (addr 0x02); bit 6 is 0 so sda_oe goes high
      i2c_start();
      write_byte(8'hA1, ack); check("rs_ack_dev", 8'(ack), 8'd0);
      wt(H); sda_m = 1'b1; wt(Q); scl = 1'b1; wt(Q); scl = 1'b0;
      waited = 0;
      while (!sda_oe && waited < 30) begin
         wt(1);
         waited++;
      end
      check("rs_oe_before", 8'(sda_oe), 8'd1);
      #2 reset = 1'b1;
      #1 check_idle_outputs("rs_async");
      sda_m = 1'b1; scl = 1'b1;
      wt(3);
      reset = 1'b0;
      wt(10);
      check_idle_outputs("rs_after");

      base_we = we_cnt;
      i2c_start();
      write_byte(8'hA0, ack); check("rw_ack_dev", 8'(ack), 8'd0);
      write_byte(8'h30, ack); check("rw_ack_wa", 8'(ack), 8'd0);
      write_byte(8'h77, ack); check("rw_ack_d0", 8'(ack), 8'd0);
      i2c_stop();
      check("rw_we_count", 8'(we_cnt - base_we), 8'd1);
      check("rw_we_addr", we_a[base_we], 8'h30);
      check("rw_we_data", we_d[base_we], 8'h77);
      check("rw_ptr_end", mem_addr, 8'h31);
      check("rw_stops", 8'(stops), 8'd6);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
